// File: rtl/uart_tx_framer_if.sv
// TX handshake bundle between the frame builder and the UART controller.
// Signal names keep the framer's point of view: o_ drives toward the controller,
// i_ returns from it.
interface uart_tx_framer_if;
  logic [55:0] o_UART_DATA_TX;
  logic        o_UART_DATA_TX_VALID;
  logic        i_UART_DATA_TX_READY;

  // Frame source (the framer)
  modport master (
    output o_UART_DATA_TX,
    output o_UART_DATA_TX_VALID,
    input  i_UART_DATA_TX_READY
  );

  // Frame sink (the UART controller)
  modport slave (
    input  o_UART_DATA_TX,
    input  o_UART_DATA_TX_VALID,
    output i_UART_DATA_TX_READY
  );
endinterface

// File: rtl/uart_tx_framer.sv
// UART TX frame builder: buffers ADS samples in a small FIFO, holds one ADS and
// one MPR register read-back each, and presents 56-bit frames one at a time.
// A frame counts as taken only on a READY 1->0 edge while VALID is held,
// because the controller may sit with READY=1 while it services an RX byte.
module uart_tx_framer #(
  parameter int         FIFO_AW               = 2,
  parameter logic [7:0] UART_SG_ADS_SEND_DATA = 8'hAA,
  parameter logic [7:0] UART_SG_ADS_READ_REG  = 8'h61,
  parameter logic [7:0] UART_SG_MPR_READ_REG  = 8'h6D
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic [47:0]        i_ADS_DATA,
  input  logic               i_ADS_DATA_VALID,
  input  logic [15:0]        i_ADS_REG_DATA,
  input  logic               i_ADS_REG_DATA_VALID,
  output logic               o_ADS_REG_DATA_READY,
  input  logic [15:0]        i_MPR_REG_DATA,
  input  logic               i_MPR_REG_DATA_VALID,
  output logic               o_MPR_REG_DATA_READY,
  uart_tx_framer_if.master   tx_bus,
  input  logic               i_DROP_CNT_CLR,
  output logic [7:0]         o_ADS_DROP_CNT,
  output logic [FIFO_AW:0]   o_FIFO_LEVEL
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic {ST_IDLE, ST_PRESENT} state_t;

  state_t r_state, w_state_next;

  // ADS sample FIFO
  logic [47:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_level;

  // Register read-back slots
  logic        r_ads_slot_full, r_mpr_slot_full;
  logic        r_ads_ready, r_mpr_ready;
  logic [15:0] r_ads_slot, r_mpr_slot;

  // Presented frame
  logic [55:0] r_tx_data;
  logic        r_tx_valid;
  logic        r_seen_ready;
  logic [7:0]  r_drop_cnt;

  logic        w_fifo_full, w_fifo_empty, w_pending, w_accept;
  logic        w_load_ads, w_load_mpr, w_pop, w_load;
  logic        w_push, w_drop;
  logic        w_ads_capture, w_mpr_capture;
  logic        w_ads_full_next, w_mpr_full_next;
  logic [55:0] w_frame;
  logic        w_tx_ready;

  assign w_tx_ready    = tx_bus.i_UART_DATA_TX_READY;
  assign w_fifo_full   = (r_level == LVL_FULL);
  assign w_fifo_empty  = (r_level == '0);
  assign w_pending     = r_ads_slot_full | r_mpr_slot_full | ~w_fifo_empty;
  assign w_accept      = (r_state == ST_PRESENT) & r_seen_ready & ~w_tx_ready;
  assign w_load        = w_load_ads | w_load_mpr | w_pop;
  // A full FIFO still accepts a sample when the head leaves in the same cycle
  assign w_push        = i_ADS_DATA_VALID & (~w_fifo_full | w_pop);
  assign w_drop        = i_ADS_DATA_VALID & w_fifo_full & ~w_pop;
  assign w_ads_capture = i_ADS_REG_DATA_VALID & r_ads_ready;
  assign w_mpr_capture = i_MPR_REG_DATA_VALID & r_mpr_ready;

  // FSM state register
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state: leave idle whenever any source has work, return on acceptance
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_pending) w_state_next = ST_PRESENT;
      ST_PRESENT: if (w_accept)  w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: fixed-priority source select and frame assembly in idle
  always_comb begin
    w_load_ads = 1'b0;
    w_load_mpr = 1'b0;
    w_pop      = 1'b0;
    w_frame    = '0;
    if (r_state == ST_IDLE) begin
      if (r_ads_slot_full) begin
        w_load_ads = 1'b1;
        w_frame    = {UART_SG_ADS_READ_REG, r_ads_slot, 32'h0};
      end else if (r_mpr_slot_full) begin
        w_load_mpr = 1'b1;
        w_frame    = {UART_SG_MPR_READ_REG, r_mpr_slot, 32'h0};
      end else if (!w_fifo_empty) begin
        w_pop      = 1'b1;
        w_frame    = {UART_SG_ADS_SEND_DATA, r_mem[r_rd_ptr]};
      end
    end
  end

  // Presented frame register: load in idle, track the READY 1->0 edge in present
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_seen_ready <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (w_load) begin
        r_tx_data    <= w_frame;
        r_tx_valid   <= 1'b1;
        r_seen_ready <= 1'b0;
      end
    end else begin
      if (w_accept)        r_tx_valid   <= 1'b0;
      else if (w_tx_ready) r_seen_ready <= 1'b1;
    end
  end

  // FIFO storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge i_CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= i_ADS_DATA;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (FIFO_AW+1)'(1);
        2'b01:   r_level <= r_level - (FIFO_AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Saturating drop counter; clear wins over a same-cycle drop
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST)                             r_drop_cnt <= '0;
    else if (i_DROP_CNT_CLR)                r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  // Next occupancy of the register slots
  always_comb begin
    w_ads_full_next = r_ads_slot_full;
    w_mpr_full_next = r_mpr_slot_full;
    if (w_load_ads)         w_ads_full_next = 1'b0;
    else if (w_ads_capture) w_ads_full_next = 1'b1;
    if (w_load_mpr)         w_mpr_full_next = 1'b0;
    else if (w_mpr_capture) w_mpr_full_next = 1'b1;
  end

  // Register slots; READY is registered so it stays low during reset
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      r_ads_slot_full <= 1'b0;
      r_mpr_slot_full <= 1'b0;
      r_ads_ready     <= 1'b0;
      r_mpr_ready     <= 1'b0;
      r_ads_slot      <= '0;
      r_mpr_slot      <= '0;
    end else begin
      r_ads_slot_full <= w_ads_full_next;
      r_mpr_slot_full <= w_mpr_full_next;
      r_ads_ready     <= ~w_ads_full_next;
      r_mpr_ready     <= ~w_mpr_full_next;
      if (w_ads_capture) r_ads_slot <= i_ADS_REG_DATA;
      if (w_mpr_capture) r_mpr_slot <= i_MPR_REG_DATA;
    end
  end

  assign tx_bus.o_UART_DATA_TX       = r_tx_data;
  assign tx_bus.o_UART_DATA_TX_VALID = r_tx_valid;
  assign o_ADS_REG_DATA_READY        = r_ads_ready;
  assign o_MPR_REG_DATA_READY        = r_mpr_ready;
  assign o_ADS_DROP_CNT              = r_drop_cnt;
  assign o_FIFO_LEVEL                = r_level;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: expected frames are queued when stimulus
// is driven and popped when the framer presents a frame.
module tb_uart_tx_framer;

  logic        clk;
  logic        rst_n;
  logic [47:0] ads_data;
  logic        ads_valid;
  logic [15:0] ads_reg;
  logic        ads_reg_valid;
  logic        ads_reg_ready;
  logic [15:0] mpr_reg;
  logic        mpr_reg_valid;
  logic        mpr_reg_ready;
  logic        drop_clr;
  logic [7:0]  drop_cnt;
  logic [2:0]  fifo_level;

  uart_tx_framer_if tx_if ();

  uart_tx_framer dut (
    .i_CLK                (clk),
    .i_RST                (rst_n),
    .i_ADS_DATA           (ads_data),
    .i_ADS_DATA_VALID     (ads_valid),
    .i_ADS_REG_DATA       (ads_reg),
    .i_ADS_REG_DATA_VALID (ads_reg_valid),
    .o_ADS_REG_DATA_READY (ads_reg_ready),
    .i_MPR_REG_DATA       (mpr_reg),
    .i_MPR_REG_DATA_VALID (mpr_reg_valid),
    .o_MPR_REG_DATA_READY (mpr_reg_ready),
    .tx_bus               (tx_if),
    .i_DROP_CNT_CLR       (drop_clr),
    .o_ADS_DROP_CNT       (drop_cnt),
    .o_FIFO_LEVEL         (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [55:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Controller model: wait for VALID, compare against the scoreboard, hold
  // READY=1 for 'hold' cycles (data must stay stable), then drop READY.
  task automatic expect_frame(input string tag, input int hold);
    logic [55:0] exp_frame;
    logic [55:0] snap;
    bit          got;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (tx_if.o_UART_DATA_TX_VALID === 1'b1) got = 1'b1;
    end
    chk({tag, "_valid_seen"}, 64'(got), 64'd1);
    if (!got) return;
    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    exp_frame = (sb.size() != 0) ? sb.pop_front() : 56'h0;
    chk({tag, "_frame"}, 64'(tx_if.o_UART_DATA_TX), 64'(exp_frame));
    $display("[TB] %s frame=0x%014h", tag, tx_if.o_UART_DATA_TX);
    snap = tx_if.o_UART_DATA_TX;
    tx_if.i_UART_DATA_TX_READY = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(tx_if.o_UART_DATA_TX_VALID), 64'd1);
      chk({tag, "_hold_data"}, 64'(tx_if.o_UART_DATA_TX), 64'(snap));
    end
    tx_if.i_UART_DATA_TX_READY = 1'b0;
    @(negedge clk);
    chk({tag, "_accept"}, 64'(tx_if.o_UART_DATA_TX_VALID), 64'd0);
  endtask

  initial begin
    logic [47:0] s;
    bit          any_valid;

    rst_n = 1'b0;
    ads_data = '0; ads_valid = 1'b0;
    ads_reg = '0;  ads_reg_valid = 1'b0;
    mpr_reg = '0;  mpr_reg_valid = 1'b0;
    drop_clr = 1'b0;
    tx_if.i_UART_DATA_TX_READY = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(tx_if.o_UART_DATA_TX_VALID), 64'd0);
    chk("rst_data", 64'(tx_if.o_UART_DATA_TX), 64'd0);
    chk("rst_ads_rdy", 64'(ads_reg_ready), 64'd0);
    chk("rst_mpr_rdy", 64'(mpr_reg_ready), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ads_rdy", 64'(ads_reg_ready), 64'd1);
    chk("rel_mpr_rdy", 64'(mpr_reg_ready), 64'd1);

    // Single sample
    tx_if.i_UART_DATA_TX_READY = 1'b1;
    ads_data = 48'h0123456789AB; ads_valid = 1'b1;
    sb.push_back(56'hAA0123456789AB);
    @(negedge clk);
    ads_valid = 1'b0;
    chk("single_level1", 64'(fifo_level), 64'd1);
    chk("single_valid_lat", 64'(tx_if.o_UART_DATA_TX_VALID), 64'd0);
    expect_frame("single", 2);
    chk("single_level0", 64'(fifo_level), 64'd0);

    // Register priority, all three sources in one cycle
    tx_if.i_UART_DATA_TX_READY = 1'b1;
    ads_reg = 16'h053C; ads_reg_valid = 1'b1;
    mpr_reg = 16'h017F; mpr_reg_valid = 1'b1;
    ads_data = 48'h111122223333; ads_valid = 1'b1;
    sb.push_back(56'h61053C00000000);
    sb.push_back(56'h6D017F00000000);
    sb.push_back(56'hAA111122223333);
    @(negedge clk);
    ads_reg_valid = 1'b0; mpr_reg_valid = 1'b0; ads_valid = 1'b0;
    chk("prio_ads_rdy_low", 64'(ads_reg_ready), 64'd0);
    chk("prio_mpr_rdy_low", 64'(mpr_reg_ready), 64'd0);
    chk("prio_level", 64'(fifo_level), 64'd1);
    expect_frame("prio_ads_reg", 1);
    expect_frame("prio_mpr_reg", 1);
    expect_frame("prio_sample", 1);
    chk("prio_ads_rdy_back", 64'(ads_reg_ready), 64'd1);
    chk("prio_mpr_rdy_back", 64'(mpr_reg_ready), 64'd1);

    // RX-collision hold: READY stays 1 for 5 clocks before falling
    ads_data = 48'hCAFEF00D1234; ads_valid = 1'b1;
    sb.push_back(56'hAACAFEF00D1234);
    @(negedge clk);
    ads_valid = 1'b0;
    expect_frame("rxhold", 5);
    any_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (tx_if.o_UART_DATA_TX_VALID === 1'b1) any_valid = 1'b1;
    end
    chk("rxhold_single_accept", 64'(any_valid), 64'd0);

    // Overflow: park one frame in present with READY low, then flood the FIFO
    tx_if.i_UART_DATA_TX_READY = 1'b0;
    ads_data = 48'h000000000F00; ads_valid = 1'b1;
    sb.push_back(56'hAA000000000F00);
    @(negedge clk);
    ads_valid = 1'b0;
    @(negedge clk);
    chk("ovf_parked_valid", 64'(tx_if.o_UART_DATA_TX_VALID), 64'd1);
    chk("ovf_parked_level", 64'(fifo_level), 64'd0);
    for (int i = 0; i < 7; i++) begin
      s = 48'h5A5A00000000 | 48'(i);
      ads_data = s; ads_valid = 1'b1;
      if (i < 4) sb.push_back({8'hAA, s});
      @(negedge clk);
    end
    ads_valid = 1'b0;
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_drop3", 64'(drop_cnt), 64'd3);
    for (int i = 0; i < 260; i++) begin
      ads_data = 48'hDEAD00000000 | 48'(i); ads_valid = 1'b1;
      @(negedge clk);
    end
    ads_valid = 1'b0;
    chk("ovf_saturate", 64'(drop_cnt), 64'd255);
    drop_clr = 1'b1; ads_data = 48'hBAD0BAD0BAD0; ads_valid = 1'b1;
    @(negedge clk);
    drop_clr = 1'b0; ads_valid = 1'b0;
    chk("ovf_clr_prio", 64'(drop_cnt), 64'd0);
    chk("ovf_clr_level", 64'(fifo_level), 64'd4);

    // Full push+pop: accept the parked frame, push during the reload cycle
    expect_frame("full_parked", 1);
    s = 48'h777788889999;
    ads_data = s; ads_valid = 1'b1;
    sb.push_back({8'hAA, s});
    @(negedge clk);
    ads_valid = 1'b0;
    chk("fullpp_level", 64'(fifo_level), 64'd4);
    chk("fullpp_drop", 64'(drop_cnt), 64'd0);
    chk("fullpp_valid", 64'(tx_if.o_UART_DATA_TX_VALID), 64'd1);
    expect_frame("fullpp_head", 1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ads_data = 48'h123400000000 | 48'(i); ads_valid = 1'b1;
      @(negedge clk);
    end
    ads_valid = 1'b0;
    chk("pre_rst_level", 64'(fifo_level), 64'd4);
    chk("pre_rst_drop", 64'(drop_cnt), 64'd1);
    chk("pre_rst_valid", 64'(tx_if.o_UART_DATA_TX_VALID), 64'd1);

    // Asynchronous reset while presenting
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(tx_if.o_UART_DATA_TX_VALID), 64'd0);
    chk("arst_data", 64'(tx_if.o_UART_DATA_TX), 64'd0);
    chk("arst_level", 64'(fifo_level), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    chk("arst_ads_rdy", 64'(ads_reg_ready), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    any_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tx_if.o_UART_DATA_TX_VALID === 1'b1) any_valid = 1'b1;
    end
    chk("arst_no_stale", 64'(any_valid), 64'd0);
    chk("arst_ads_rdy_rel", 64'(ads_reg_ready), 64'd1);
    chk("arst_mpr_rdy_rel", 64'(mpr_reg_ready), 64'd1);

    // Operation resumes after reset
    ads_data = 48'hFEDCBA987654; ads_valid = 1'b1;
    sb.push_back(56'hAAFEDCBA987654);
    @(negedge clk);
    ads_valid = 1'b0;
    expect_frame("resume", 1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Upstream feeder of the UART controller's TX path.
- Collects ADS1292 sample data and ADS/MPR register read-back responses from the core, builds 56-bit UART TX frames with the protocol header byte, and presents them one at a time on the controller's TX data/valid/ready port.
- Buffers streaming ADS samples in a small FIFO so sample bursts survive while the controller serialises a frame.
- Counts samples dropped on FIFO overflow.

Parameters:
- FIFO_AW, 2: ADS FIFO address width; depth = 2**FIFO_AW.
- UART_SG_ADS_SEND_DATA, 8'hAA: header byte for ADS sample frames.
- UART_SG_ADS_READ_REG, 8'h61: header byte for ADS register read-back frames.
- UART_SG_MPR_READ_REG, 8'h6D: header byte for MPR register read-back frames.

Ports:
- i_CLK  in  1  system clock.
- i_RST  in  1  asynchronous, active-low reset (0 = reset).
- i_ADS_DATA  in  48  ADS sample payload (status/ch1/ch2 packed, MSB first).
- i_ADS_DATA_VALID  in  1  single-cycle push strobe; no backpressure.
- i_ADS_REG_DATA  in  16  {reg_addr[15:8], reg_data[7:0]}.
- i_ADS_REG_DATA_VALID  in  1  ADS read-back valid.
- o_ADS_REG_DATA_READY  out  1  ADS read-back slot empty.
- i_MPR_REG_DATA  in  16  {reg_addr, reg_data}.
- i_MPR_REG_DATA_VALID  in  1  MPR read-back valid.
- o_MPR_REG_DATA_READY  out  1  MPR read-back slot empty.
- o_UART_DATA_TX  out  56  frame to the UART controller.
- o_UART_DATA_TX_VALID  out  1  frame valid.
- i_UART_DATA_TX_READY  in  1  controller ready.
- i_DROP_CNT_CLR  in  1  synchronous clear of the drop counter.
- o_ADS_DROP_CNT  out  8  saturating count of dropped samples.
- o_FIFO_LEVEL  out  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset (i_RST=0, async): o_UART_DATA_TX=0, o_UART_DATA_TX_VALID=0, both REG_DATA_READY=0, o_ADS_DROP_CNT=0, o_FIFO_LEVEL=0. FIFO pointers, slots, seen_ready and state are cleared.
- After reset release, both REG_DATA_READY=1 from the first clock.
- Reset mid-frame discards the frame and all buffered data.
- Frame formats:
  - ADS sample = {8'hAA, data[47:0]}.
  - ADS reg = {8'h61, addr, data, 32'h0}.
  - MPR reg = {8'h6D, addr, data, 32'h0}.
- Register slots: one entry each; READY = slot empty. Capture on VALID&READY. READY drops the next cycle and rises the cycle after the slot is loaded into a frame.
- ADS FIFO push:
  - On i_ADS_DATA_VALID when not full.
  - When full and no pop in the same cycle, the new sample is dropped and o_ADS_DROP_CNT increments, saturating at 255.
  - Push and pop in the same cycle when full: push succeeds, level unchanged.
  - i_DROP_CNT_CLR has priority over a same-cycle drop; the counter becomes 0.
- Source priority at load: ADS reg slot > MPR reg slot > ADS FIFO head. Fixed priority, no fairness.
- FSM, 2 states:
  - ST_IDLE: VALID=0. If any source is pending: load the highest-priority frame into o_UART_DATA_TX, pop that source, set VALID=1, clear seen_ready, go to ST_PRESENT. Latency is 1 clock from pending to VALID. Otherwise stay.
  - ST_PRESENT: VALID=1; o_UART_DATA_TX is held stable. A cycle with i_UART_DATA_TX_READY=1 sets seen_ready. Acceptance is seen_ready=1 and i_UART_DATA_TX_READY=0 in the current cycle. On acceptance, VALID<=0 and go to ST_IDLE. Otherwise stay.
  - Minimum spacing between frames is 2 clocks.
- Handshake rule: the controller may leave READY=1 without capturing when it services an RX byte that cycle. A frame is therefore only considered taken on the READY 1->0 edge while VALID is held; VALID&READY alone is not acceptance.
- READY=0 at entry to ST_PRESENT (controller still serialising): the framer waits; acceptance requires a fresh 1 then 0.
- o_FIFO_LEVEL is the registered occupancy, in the range 0..2**FIFO_AW.

Test Plan:
- Single sample: push data=48'h0123456789AB; controller model holds READY=1, then 0 two cycles after VALID -> o_UART_DATA_TX=56'hAA0123456789AB, VALID high 1 clock after push, low 1 clock after READY falls, level 1->0.
- Register priority: same cycle ADS reg {8'h05,8'h3C}, MPR reg {8'h01,8'h7F}, FIFO holding 1 sample, READY idle at 1 -> frames in order 56'h61053C00000000, 56'h6D017F00000000, then AA frame.
- RX-collision hold: VALID asserted, READY stays 1 for 5 clocks, then falls -> VALID and data unchanged for all 5 clocks; exactly one acceptance.
- Overflow: FIFO_AW=2, READY held 0, push 7 samples -> level 4, o_ADS_DROP_CNT=3; 260 further pushes -> count saturates at 255; pulse i_DROP_CNT_CLR with a simultaneous push -> count 0.
- Full push+pop: FIFO full; in the load cycle, push a new sample -> level stays 4, drop count unchanged.
- Async reset in ST_PRESENT: drive i_RST=0 mid-cycle -> VALID, data, level and counter go to 0 immediately; after release, REG_DATA_READY=1 and no stale frame is emitted.
